// File: rtl/video_sync_gen.sv
// Programmable raster timing generator with an 8-bit CPU register port.
// Produces registered sync/display-enable/coordinates plus a scanline and vertical-blank interrupt.
module video_sync_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic       wren,
  input  logic       ren,
  input  logic [1:0] addr,
  input  logic [7:0] from_cpu,
  output logic [7:0] to_cpu,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       pix_stb,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       sync_int
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]    V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]    HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]    HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]    VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]    VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic [1:0] {
    REG_CTRL    = 2'd0,
    REG_CMP_LO  = 2'd1,
    REG_CMP_HI  = 2'd2,
    REG_INT_CLR = 2'd3
  } reg_addr_e;

  logic [2:0]    ctrl;
  logic [9:0]    cmp;
  logic          line_f;
  logic          vbl_f;
  logic [PW-1:0] presc;

  logic          wr;
  logic          rd;
  logic          en_nxt;
  logic          wrap;
  logic [9:0]    x_nxt;
  logic [9:0]    y_nxt;
  logic          de_nxt;
  logic          hsync_nxt;
  logic          vsync_nxt;
  logic          line_set;
  logic          vbl_set;
  logic          line_clr;
  logic          vbl_clr;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    wr        = ce & wren;
    rd        = ce & ren;
    en_nxt    = ctrl[0];
    pix_stb   = ctrl[0] && (presc == PRE_LAST);
    wrap      = 1'b0;
    x_nxt     = x;
    y_nxt     = y;
    line_clr  = 1'b0;
    vbl_clr   = 1'b0;

    if (wr && addr == REG_CTRL) en_nxt = from_cpu[0];
    if (wr && addr == REG_INT_CLR) begin
      line_clr = from_cpu[0];
      vbl_clr  = from_cpu[1];
    end

    if (pix_stb) begin
      if (x == H_LAST) begin
        wrap  = 1'b1;
        x_nxt = '0;
        y_nxt = (y == V_LAST) ? '0 : y + 10'd1;
      end else begin
        x_nxt = x + 10'd1;
      end
    end

    // Decodes look at the post-update position so they stay aligned with x/y.
    de_nxt    = (x_nxt < H_ACT) && (y_nxt < V_ACT);
    hsync_nxt = !((x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST));
    vsync_nxt = !((y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST));

    // A compare value past the last line can never equal y_nxt; the bound keeps that explicit.
    line_set  = wrap && en_nxt && (y_nxt == cmp) && (cmp <= V_LAST);
    vbl_set   = wrap && en_nxt && (y_nxt == V_ACT);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      x     <= '0;
      y     <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      de    <= 1'b0;
    end else if (!en_nxt) begin
      presc <= '0;
      x     <= '0;
      y     <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
      de    <= 1'b0;
    end else begin
      presc <= (!ctrl[0] || pix_stb) ? '0 : presc + PRE_ONE;
      // The enabling edge loads the decodes for (0,0) so outputs agree with x/y at once.
      if (pix_stb || !ctrl[0]) begin
        x     <= x_nxt;
        y     <= y_nxt;
        hsync <= hsync_nxt;
        vsync <= vsync_nxt;
        de    <= de_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl   <= '0;
      cmp    <= '0;
      line_f <= 1'b0;
      vbl_f  <= 1'b0;
    end else begin
      if (wr) begin
        case (addr)
          REG_CTRL:   ctrl      <= from_cpu[2:0];
          REG_CMP_LO: cmp[7:0]  <= from_cpu;
          REG_CMP_HI: cmp[9:8]  <= from_cpu[1:0];
          default:    ;
        endcase
      end
      line_f <= line_set | (line_f & ~line_clr);
      vbl_f  <= vbl_set  | (vbl_f  & ~vbl_clr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cpu <= '0;
    end else if (rd) begin
      case (addr)
        REG_CTRL:   to_cpu <= {5'b0, ctrl};
        REG_CMP_LO: to_cpu <= y[7:0];
        REG_CMP_HI: to_cpu <= {6'b0, y[9:8]};
        default:    to_cpu <= {4'b0, ~vsync, ~hsync, vbl_f, line_f};
      endcase
    end
  end

  assign sync_int = (line_f & ctrl[1]) | (vbl_f & ctrl[2]);

endmodule

// File: tb/tb_video_sync_gen.sv
// Scoreboard bench for video_sync_gen on a shrunken raster (15x10 pixels, 2 clk/pixel).
// A position model derived from elapsed cycles predicts every pixel step and register read.
module tb_video_sync_gen;

  localparam int D  = 2;
  localparam int HA = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VA = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT * D;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       de;
    logic       hs;
    logic       vs;
  } pix_t;

  localparam pix_t PIX_OFF = '{x: 10'd0, y: 10'd0, de: 1'b0, hs: 1'b1, vs: 1'b1};

  logic       clk;
  logic       rst_n;
  logic       ce;
  logic       wren;
  logic       ren;
  logic [1:0] addr;
  logic [7:0] from_cpu;
  logic [7:0] to_cpu;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic       pix_stb;
  logic [9:0] x;
  logic [9:0] y;
  logic       sync_int;

  int checks = 0;
  int errors = 0;

  video_sync_gen #(
    .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .wren(wren), .ren(ren), .addr(addr),
    .from_cpu(from_cpu), .to_cpu(to_cpu), .hsync(hsync), .vsync(vsync), .de(de),
    .pix_stb(pix_stb), .x(x), .y(y), .sync_int(sync_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Raster position after k clk edges of running: pixel index is k/D, wrapped per frame.
  function automatic pix_t pos_at(input int k);
    pix_t p;
    int q, px, py;
    q    = (k / D) % (HT * VT);
    px   = q % HT;
    py   = q / HT;
    p.x  = 10'(px);
    p.y  = 10'(py);
    p.de = (px < HA) && (py < VA);
    p.hs = !((px >= HA + HF) && (px < HA + HF + HS));
    p.vs = !((py >= VA + VF) && (py < VA + VF + VS));
    return p;
  endfunction

  // Reference model state and expectation queues.
  logic [2:0] m_ctrl;
  logic [9:0] m_cmp;
  logic       m_line_f;
  logic       m_vbl_f;
  int         m_k;
  pix_t       pix_q[$];
  logic [7:0] rd_q[$];

  pix_t       cur;
  pix_t       nxt;
  logic       stb;
  logic       n_en;
  logic       lset;
  logic       vset;
  logic       lclr;
  logic       vclr;
  logic [7:0] rdat;
  logic       exp_int;

  always_comb begin
    cur     = m_ctrl[0] ? pos_at(m_k) : PIX_OFF;
    stb     = m_ctrl[0] && ((m_k % D) == D - 1);
    n_en    = (ce && wren && addr == 2'd0) ? from_cpu[0] : m_ctrl[0];
    nxt     = !n_en ? PIX_OFF : pos_at(m_ctrl[0] ? m_k + 1 : 0);
    lset    = stb && n_en && nxt.x == 10'd0 && nxt.y == m_cmp;
    vset    = stb && n_en && nxt.x == 10'd0 && nxt.y == 10'(VA);
    lclr    = ce && wren && addr == 2'd3 && from_cpu[0];
    vclr    = ce && wren && addr == 2'd3 && from_cpu[1];
    exp_int = (m_line_f && m_ctrl[1]) || (m_vbl_f && m_ctrl[2]);
    case (addr)
      2'd0:    rdat = {5'b0, m_ctrl};
      2'd1:    rdat = cur.y[7:0];
      2'd2:    rdat = {6'b0, cur.y[9:8]};
      default: rdat = {4'b0, ~cur.vs, ~cur.hs, m_vbl_f, m_line_f};
    endcase
  end

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_ctrl   <= '0;
        m_cmp    <= '0;
        m_line_f <= 1'b0;
        m_vbl_f  <= 1'b0;
        m_k      <= 0;
        pix_q.delete();
        rd_q.delete();
      end else begin
        if (stb) pix_q.push_back(nxt);
        if (ce && ren) rd_q.push_back(rdat);
        m_k <= (n_en && m_ctrl[0]) ? m_k + 1 : 0;
        if (ce && wren) begin
          case (addr)
            2'd0:    m_ctrl      <= from_cpu[2:0];
            2'd1:    m_cmp[7:0]  <= from_cpu;
            2'd2:    m_cmp[9:8]  <= from_cpu[1:0];
            default: ;
          endcase
        end
        m_line_f <= lset || (m_line_f && !lclr);
        m_vbl_f  <= vset || (m_vbl_f && !vclr);
      end
    end
  end

  // Monitor: a strobe seen in one cycle means a new pixel is presented after the next edge.
  logic stb_seen;
  pix_t exp_pix;

  initial begin
    stb_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stb_seen = 1'b0;
      end else begin
        if (stb_seen) begin
          if (pix_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pix_extra: strobe with no expected pixel, x=%0d y=%0d", x, y);
          end else begin
            exp_pix = pix_q.pop_front();
            check("pix_x", 32'(x), 32'(exp_pix.x));
            check("pix_y", 32'(y), 32'(exp_pix.y));
            check("pix_de", 32'(de), 32'(exp_pix.de));
            check("pix_hsync", 32'(hsync), 32'(exp_pix.hs));
            check("pix_vsync", 32'(vsync), 32'(exp_pix.vs));
          end
        end
        while (rd_q.size() > 0) check("to_cpu", 32'(to_cpu), 32'(rd_q.pop_front()));
        check("sync_int", 32'(sync_int), 32'(exp_int));
        stb_seen = pix_stb;
      end
    end
  end

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    ce = 1'b1; wren = 1'b1; addr = a; from_cpu = d;
    @(negedge clk);
    ce = 1'b0; wren = 1'b0;
  endtask

  task automatic cpu_rd(input logic [1:0] a);
    @(negedge clk);
    ce = 1'b1; ren = 1'b1; addr = a;
    @(negedge clk);
    ce = 1'b0; ren = 1'b0;
  endtask

  // sel: 0 hsync, 1 vsync, 2 sync_int. Returns the cycle index when the level is seen.
  task automatic wait_sig(input int sel, input logic lvl, input int budget, input string name,
                          output int t, output bit ok);
    logic v;
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      v = (sel == 0) ? hsync : (sel == 1) ? vsync : sync_int;
      if (v == lvl) begin
        ok = 1'b1;
        t  = int'($time / 10);
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s: timeout after %0d cycles waiting for level %0b", name, budget, lvl);
  endtask

  int         t0, t1, t2, de_cnt, de_bad;
  bit         ok;
  logic [9:0] cmpv;
  logic [1:0] ra;
  logic [7:0] rd_data;

  initial begin
    rst_n = 1'b0; ce = 1'b0; wren = 1'b0; ren = 1'b0; addr = '0; from_cpu = '0;
    repeat (2) @(negedge clk);
    check("rst_x", 32'(x), 0);
    check("rst_y", 32'(y), 0);
    check("rst_hsync", 32'(hsync), 1);
    check("rst_vsync", 32'(vsync), 1);
    check("rst_de", 32'(de), 0);
    check("rst_pix_stb", 32'(pix_stb), 0);
    check("rst_to_cpu", 32'(to_cpu), 0);
    check("rst_sync_int", 32'(sync_int), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_x", 32'(x), 0);
    check("idle_pix_stb", 32'(pix_stb), 0);

    // Sync timing measured in clk cycles.
    cpu_wr(2'd0, 8'h01);
    wait_sig(0, 1'b1, FRAME, "hs_high", t0, ok);
    wait_sig(0, 1'b0, FRAME, "hs_fall0", t0, ok);
    wait_sig(0, 1'b1, FRAME, "hs_rise", t1, ok);
    wait_sig(0, 1'b0, FRAME, "hs_fall1", t2, ok);
    check("hsync_low_width", 32'(t1 - t0), 32'(HS * D));
    check("line_period", 32'(t2 - t0), 32'(HT * D));
    wait_sig(1, 1'b1, 2 * FRAME, "vs_high", t0, ok);
    wait_sig(1, 1'b0, 2 * FRAME, "vs_fall0", t0, ok);
    wait_sig(1, 1'b1, 2 * FRAME, "vs_rise", t1, ok);
    wait_sig(1, 1'b0, 2 * FRAME, "vs_fall1", t2, ok);
    check("vsync_low_width", 32'(t1 - t0), 32'(VS * HT * D));
    check("frame_period", 32'(t2 - t0), 32'(FRAME));

    de_cnt = 0;
    de_bad = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (de) de_cnt++;
      if (de && y >= 10'(VA)) de_bad++;
    end
    check("de_cycles_per_frame", 32'(de_cnt), 32'(HA * VA * D));
    check("de_in_vblank", 32'(de_bad), 0);

    // Scanline interrupt at random in-range compare lines.
    for (int n = 0; n < 5; n++) begin
      cmpv = 10'($urandom_range(VT - 1, 0));
      cpu_wr(2'd0, 8'h02);
      cpu_wr(2'd1, cmpv[7:0]);
      cpu_wr(2'd2, {6'b0, cmpv[9:8]});
      cpu_wr(2'd3, 8'h03);
      cpu_wr(2'd0, 8'h03);
      wait_sig(2, 1'b1, 2 * FRAME, "line_irq", t0, ok);
      if (ok) begin
        check("line_irq_y", 32'(y), 32'(cmpv));
        check("line_irq_x", 32'(x), 0);
      end
      cpu_wr(2'd3, 8'h01);
      check("line_irq_cleared", 32'(sync_int), 0);
      cpu_rd(2'd3);
      check("line_f_read_back", 32'(to_cpu[0]), 0);
    end

    // Out-of-range compare never fires.
    cmpv = 10'($urandom_range(1023, VT));
    cpu_wr(2'd0, 8'h02);
    cpu_wr(2'd1, cmpv[7:0]);
    cpu_wr(2'd2, {6'b0, cmpv[9:8]});
    cpu_wr(2'd3, 8'h03);
    cpu_wr(2'd0, 8'h03);
    repeat (FRAME + HT * D) @(negedge clk);
    check("cmp_out_of_range", 32'(sync_int), 0);

    // Vertical-blank interrupt.
    cpu_wr(2'd0, 8'h04);
    cpu_wr(2'd3, 8'h03);
    cpu_wr(2'd0, 8'h05);
    wait_sig(2, 1'b1, 2 * FRAME, "vbl_irq", t0, ok);
    if (ok) begin
      check("vbl_irq_y", 32'(y), 32'(VA));
      check("vbl_irq_x", 32'(x), 0);
    end

    // Clear issued on the very edge that sets VBL_F: the set must win.
    cpu_wr(2'd0, 8'h04);
    cpu_wr(2'd3, 8'h03);
    cpu_wr(2'd0, 8'h05);
    repeat (VA * HT * D - 1) @(negedge clk);
    ce = 1'b1; wren = 1'b1; addr = 2'd3; from_cpu = 8'h02;
    @(negedge clk);
    ce = 1'b0; wren = 1'b0;
    check("vbl_set_wins", 32'(sync_int), 1);
    check("vbl_set_y", 32'(y), 32'(VA));

    // Mid-frame disable, then restart from the origin.
    cpu_wr(2'd3, 8'h03);
    cpu_wr(2'd0, 8'h01);
    repeat ($urandom_range(250, 40)) @(negedge clk);
    cpu_wr(2'd0, 8'h00);
    check("dis_x", 32'(x), 0);
    check("dis_y", 32'(y), 0);
    check("dis_hsync", 32'(hsync), 1);
    check("dis_vsync", 32'(vsync), 1);
    check("dis_de", 32'(de), 0);
    cpu_wr(2'd0, 8'h01);
    check("reen_stb_cycle0", 32'(pix_stb), 0);
    check("reen_x0", 32'(x), 0);
    @(negedge clk);
    check("reen_stb_cycle1", 32'(pix_stb), 1);
    @(negedge clk);
    check("reen_x1", 32'(x), 1);

    // Random register traffic; the model predicts every read and interrupt level.
    for (int n = 0; n < 150; n++) begin
      ra      = 2'($urandom_range(3, 0));
      rd_data = 8'($urandom);
      if (ra == 2'd0 && $urandom_range(9, 0) < 8) rd_data[0] = 1'b1;
      if ($urandom_range(1, 0) == 1) cpu_wr(ra, rd_data);
      else cpu_rd(ra);
      repeat ($urandom_range(($urandom_range(7, 0) == 0) ? 60 : 6, 0)) @(negedge clk);
    end

    // Asynchronous reset between clock edges.
    cpu_wr(2'd0, 8'h07);
    cpu_rd(2'd0);
    repeat (37) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_x", 32'(x), 0);
    check("arst_y", 32'(y), 0);
    check("arst_hsync", 32'(hsync), 1);
    check("arst_vsync", 32'(vsync), 1);
    check("arst_de", 32'(de), 0);
    check("arst_pix_stb", 32'(pix_stb), 0);
    check("arst_to_cpu", 32'(to_cpu), 0);
    check("arst_sync_int", 32'(sync_int), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    cpu_rd(2'd0);
    check("ctrl_after_reset", 32'(to_cpu), 0);

    cpu_wr(2'd0, 8'h00);
    repeat (3) @(negedge clk);
    #1;
    check("pix_q_drained", 32'(pix_q.size()), 0);
    check("rd_q_drained", 32'(rd_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
